// File: rtl/load_store_unit_if.sv
// Execute-stage request/response channel and word-addressed data-memory port
// of the load/store unit, bundled with initiator (master) and unit (slave) views.
interface load_store_unit_if;
   // A request transfers on a rising edge where req_valid and req_ready are both
   // high; resp_valid is a one-cycle pulse and resp_rdata/resp_err are qualified by it.
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-only data memory; sub-word stores are
// performed as read-modify-write, illegal accesses answer with an error.
module load_store_unit (
   input  logic              clk,
   input  logic              rst_n,
   load_store_unit_if.slave  bus,
   output logic [2:0]        dbg_state
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic [2:0]  f3_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;
   logic        accept;
   logic        legal;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;
   logic [31:0] merged;

   assign accept = bus.req_valid && bus.req_ready;

   // Width and alignment legality of the incoming request.
   always_comb begin
      legal = 1'b0;
      case (bus.req_funct3)
         3'd0:    legal = 1'b1;
         3'd1:    legal = ~bus.req_addr[0];
         3'd2:    legal = (bus.req_addr[1:0] == 2'b00);
         3'd4:    legal = ~bus.req_we;
         3'd5:    legal = ~bus.req_we & ~bus.req_addr[0];
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!legal)                   state_nx = RESP;
               else if (!bus.req_we)         state_nx = LOAD;
               else if (bus.req_funct3 == 3'd2) state_nx = WRITE;
               else                          state_nx = READ;
            end
         end
         LOAD:    state_nx = RESP;
         READ:    state_nx = WRITE;
         WRITE:   state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      ld_byte  = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
      ld_half  = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
      load_val = bus.mem_rd;
      case (f3_q)
         3'd0:    load_val = {{24{ld_byte[7]}}, ld_byte};
         3'd1:    load_val = {{16{ld_half[15]}}, ld_half};
         3'd4:    load_val = {24'd0, ld_byte};
         3'd5:    load_val = {16'd0, ld_half};
         default: load_val = bus.mem_rd;
      endcase
   end

   // Only the addressed lane of the captured word is replaced.
   always_comb begin
      merged = merge_q;
      if (f3_q == 3'd0)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         merge_q      <= 32'd0;
         f3_q         <= 3'd0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            f3_q    <= bus.req_funct3;
            if (!legal) begin
               resp_rdata_q <= 32'd0;
               resp_err_q   <= 1'b1;
            end
         end
         if (state == LOAD) begin
            resp_rdata_q <= load_val;
            resp_err_q   <= 1'b0;
         end
         if (state == READ)
            merge_q <= bus.mem_rd;
         if (state == WRITE) begin
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
         end
      end
   end

   // Gating with rst_n keeps a WRITE cycle under reset from touching memory.
   assign bus.req_ready  = (state == IDLE) && rst_n;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.mem_a      = {addr_q[31:2], 2'b00};
   assign bus.mem_we     = (state == WRITE) && rst_n;
   assign bus.mem_wd     = (state != WRITE) ? 32'd0 :
                           (f3_q == 3'd2)   ? wdata_q : merged;
   assign dbg_state      = state;
endmodule
